// File: rtl/wrr_hold_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// wrr_hold_pkg : shared FSM type and weight helper for wrr_hold_arbiter
// Revision 1.0
// ============================================================================
package wrr_hold_pkg;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} wrr_state_e;

  localparam int MAX_WW = 32;

  function automatic logic [MAX_WW-1:0] clamp_weight(input logic [MAX_WW-1:0] w);
    return (w == '0) ? MAX_WW'(1) : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wrr_hold_arbiter_if.sv
`default_nettype none
// ============================================================================
// wrr_hold_if : request/weight/grant bundle for wrr_hold_arbiter
// Revision 1.0  (gnt_cnt present only with WRR_HOLD_GNT_CNT_EN)
// ============================================================================
interface wrr_hold_if #(
  parameter int N     = 4,
  parameter int WW    = 4,
  parameter int CNT_W = 16
);

  logic [N-1:0]         req;
  logic [N*WW-1:0]      weight;
  logic [N-1:0]         gnt;
  logic                 gnt_vld;
  logic [$clog2(N)-1:0] gnt_id;

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("wrr_hold_if: CNT_W must be at least 1");
  end

`ifdef WRR_HOLD_GNT_CNT_EN
  logic [N*CNT_W-1:0]   gnt_cnt;

  modport master (output req, weight, input gnt, gnt_vld, gnt_id, gnt_cnt);
  modport slave  (input req, weight, output gnt, gnt_vld, gnt_id, gnt_cnt);
`else
  modport master (output req, weight, input gnt, gnt_vld, gnt_id);
  modport slave  (input req, weight, output gnt, gnt_vld, gnt_id);
`endif

endinterface
`default_nettype wire

// File: rtl/wrr_hold_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational rotating-priority picker, first set bit from ptr up
// Revision 1.0
// ============================================================================
module rr_pick #(
  parameter int N = 4
) (
  input  wire logic [N-1:0]         req,
  input  wire logic [$clog2(N)-1:0] ptr,
  output logic      [N-1:0]         pick,
  output logic      [$clog2(N)-1:0] pick_idx,
  output logic                      any
);

  localparam int PW = $clog2(N);

  logic [PW:0] idx_w;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    idx_w    = '0;
    for (int k = 0; k < N; k++) begin
      // ptr + k is below 2N, so one conditional subtract gives the modulo
      idx_w = {1'b0, ptr} + (PW+1)'(k);
      if (idx_w >= (PW+1)'(N)) begin
        idx_w = idx_w - (PW+1)'(N);
      end
      if (!any && req[idx_w[PW-1:0]]) begin
        any                   = 1'b1;
        pick_idx              = idx_w[PW-1:0];
        pick[idx_w[PW-1:0]]   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wrr_hold_arbiter.sv
`default_nettype none
// ============================================================================
// wrr_hold_arbiter : weighted round-robin arbiter with grant hold and
// zero-bubble handoff. Optional grant-event counters: WRR_HOLD_GNT_CNT_EN.
// Revision 1.0
// ============================================================================
module wrr_hold_arbiter
  import wrr_hold_pkg::*;
#(
  parameter int N     = 4,
  parameter int WW    = 4,
  parameter int CNT_W = 16
) (
  input  wire logic clk,
  input  wire logic rstn,
  wrr_hold_if.slave bus
);

  localparam int PW = $clog2(N);

  if (N < 2 || N > 16 || WW < 1 || WW > MAX_WW || CNT_W < 1) begin : g_param_chk
    $error("wrr_hold_arbiter: parameter out of range");
  end

  wrr_state_e     state, state_nxt;
  logic [PW-1:0]  ptr, ptr_nxt;
  logic [PW-1:0]  holder, holder_nxt;
  logic [WW-1:0]  credit, credit_nxt;
  logic [N-1:0]   gnt_q, gnt_nxt;
  logic           vld_q, vld_nxt;
  logic           start;

  logic [WW-1:0]  w_arr [N];
  logic [PW-1:0]  ptr_after;
  logic [PW-1:0]  pick_ptr;
  logic [N-1:0]   pick;
  logic [PW-1:0]  pick_idx;
  logic           pick_any;

  for (genvar i = 0; i < N; i++) begin : g_w
    assign w_arr[i] = bus.weight[i*WW +: WW];
  end

  // On release the picker must already see the rotated pointer, so IDLE and
  // release can share one picker instance.
  assign ptr_after = (holder == PW'(N-1)) ? '0 : holder + PW'(1);
  assign pick_ptr  = (state == HOLD) ? ptr_after : ptr;

  rr_pick #(.N(N)) u_pick (
    .req      (bus.req),
    .ptr      (pick_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    holder_nxt = holder;
    credit_nxt = credit;
    gnt_nxt    = gnt_q;
    vld_nxt    = vld_q;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) start = 1'b1;
      end
      HOLD: begin
        if (bus.req[holder] && credit > WW'(1)) begin
          credit_nxt = credit - WW'(1);
        end else begin
          ptr_nxt = ptr_after;
          if (pick_any) begin
            start = 1'b1;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            vld_nxt   = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (start) begin
      state_nxt  = HOLD;
      holder_nxt = pick_idx;
      credit_nxt = WW'(clamp_weight(MAX_WW'(w_arr[pick_idx])));
      gnt_nxt    = pick;
      vld_nxt    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      ptr    <= '0;
      holder <= '0;
      credit <= '0;
      gnt_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      holder <= holder_nxt;
      credit <= credit_nxt;
      gnt_q  <= gnt_nxt;
      vld_q  <= vld_nxt;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_vld = vld_q;
  assign bus.gnt_id  = holder;

`ifdef WRR_HOLD_GNT_CNT_EN
  logic [CNT_W-1:0] cnt_q [N];

  for (genvar i = 0; i < N; i++) begin : g_cnt
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cnt_q[i] <= '0;
      end else if (start && pick_idx == PW'(i) && cnt_q[i] != '1) begin
        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
    assign bus.gnt_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wrr_hold_arbiter.sv
`default_nettype none
// ============================================================================
// tb_wrr_hold_arbiter : directed and randomized checks against a cycle-count
// reference model of the weighted hold arbiter.
// ============================================================================
module tb_wrr_hold_arbiter;

  localparam int N     = 4;
  localparam int WW    = 4;
  localparam int CNT_W = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  int errors = 0;
  int checks = 0;

  wrr_hold_if #(.N(N), .WW(WW), .CNT_W(CNT_W)) bus ();

  wrr_hold_arbiter #(.N(N), .WW(WW), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: who holds, how many cycles it has been granted, its limit.
  bit m_busy;
  int m_holder, m_used, m_limit, m_ptr;
  int m_cnt [N];

  task automatic model_reset();
    m_busy = 0; m_holder = 0; m_used = 0; m_limit = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  function automatic int find_from(int p, logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_start(int i, logic [N*WW-1:0] w);
    int wi;
    wi       = int'(w[i*WW +: WW]);
    m_busy   = 1;
    m_holder = i;
    m_used   = 1;
    m_limit  = (wi == 0) ? 1 : wi;
    if (m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i]++;
  endtask

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_busy) g[m_holder] = 1'b1;
    return g;
  endfunction

  // One clock: model consumes the inputs present at the edge, outputs sampled 1 later.
  task automatic tick();
    logic [N-1:0]    r;
    logic [N*WW-1:0] w;
    int j;
    @(posedge clk);
    r = bus.req;
    w = bus.weight;
    if (m_busy) begin
      if (r[m_holder] && m_used < m_limit) begin
        m_used++;
      end else begin
        m_ptr = (m_holder + 1) % N;
        j = find_from(m_ptr, r);
        if (j >= 0) model_start(j, w);
        else m_busy = 0;
      end
    end else if (r != '0) begin
      model_start(find_from(m_ptr, r), w);
    end
    #1;
  endtask

  task automatic do_reset();
    bus.req    = '0;
    bus.weight = '0;
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    bus.req    = 4'b1111;
    bus.weight = {4'd3, 4'd3, 4'd3, 4'd3};
    rstn = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
    checks++; if (bus.gnt_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", bus.gnt_vld); end
    checks++; if (bus.gnt_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", bus.gnt_id); end
    bus.req = '0;
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_equal_weights();
    logic [N-1:0] e;
    do_reset();
    bus.weight = {4'd2, 4'd2, 4'd2, 4'd2};
    bus.req    = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      tick();
      e = '0;
      e[(c / 2) % 4] = 1'b1;
      checks++;
      if (bus.gnt !== e || bus.gnt_vld !== 1'b1) begin
        errors++; $display("FAIL equal_w cyc=%0d got=%b vld=%b exp=%b vld=1", c, bus.gnt, bus.gnt_vld, e);
      end
    end
  endtask

  task automatic test_weighted();
    logic [N-1:0] e;
    do_reset();
    bus.weight = {4'd2, 4'd0, 4'd1, 4'd3};
    bus.req    = 4'b0101;
    for (int c = 0; c < 16; c++) begin
      tick();
      e = ((c % 4) < 3) ? 4'b0001 : 4'b0100;
      checks++;
      if (bus.gnt !== e) begin
        errors++; $display("FAIL weighted cyc=%0d got=%b exp=%b", c, bus.gnt, e);
      end
    end
  endtask

  task automatic test_single_pulse();
    do_reset();
    bus.weight = {4'd5, 4'd5, 4'd5, 4'd5};
    bus.req    = 4'b0010;
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL pulse_gnt got=%b exp=0010", bus.gnt); end
    bus.req = 4'b0000;
    tick();
    checks++; if (bus.gnt !== 4'b0000 || bus.gnt_vld !== 1'b0) begin errors++; $display("FAIL pulse_drop got=%b vld=%b exp=0000 vld=0", bus.gnt, bus.gnt_vld); end
    tick();
    checks++; if (bus.gnt_id !== 2'd1) begin errors++; $display("FAIL pulse_id_hold got=%0d exp=1", bus.gnt_id); end
    // ptr moved past requester 1, so requester 2 wins next
    bus.req = 4'b1111;
    tick();
    checks++; if (bus.gnt !== 4'b0100 || bus.gnt_id !== 2'd2) begin errors++; $display("FAIL pulse_ptr got=%b id=%0d exp=0100 id=2", bus.gnt, bus.gnt_id); end
  endtask

  task automatic test_drop_handoff();
    do_reset();
    bus.weight = {4'd8, 4'd8, 4'd8, 4'd8};
    bus.req    = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL drop_hold cyc=%0d got=%b exp=0010", c, bus.gnt); end
    end
    bus.req = 4'b1000;
    tick();
    checks++; if (bus.gnt !== 4'b1000 || bus.gnt_vld !== 1'b1) begin errors++; $display("FAIL drop_handoff got=%b vld=%b exp=1000 vld=1", bus.gnt, bus.gnt_vld); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.weight = {4'd8, 4'd8, 4'd8, 4'd8};
    bus.req    = 4'b0100;
    tick();
    tick();
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL async_gnt got=%b exp=0000", bus.gnt); end
    checks++; if (bus.gnt_vld !== 1'b0) begin errors++; $display("FAIL async_vld got=%b exp=0", bus.gnt_vld); end
    checks++; if (bus.gnt_id !== 2'd0) begin errors++; $display("FAIL async_id got=%0d exp=0", bus.gnt_id); end
    bus.req = 4'b1000;
    #1;
    rstn = 1'b1;
    model_reset();
    tick();
    checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL async_regrant got=%b exp=1000", bus.gnt); end
  endtask

`ifdef WRR_HOLD_GNT_CNT_EN
  task automatic test_cnt_saturate();
    int e;
    do_reset();
    bus.weight = {4'd0, 4'd0, 4'd0, 4'd1};
    bus.req    = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      tick();
      e = (c + 1 < 3) ? c + 1 : 3;
      checks++;
      if (int'(bus.gnt_cnt[0 +: CNT_W]) != e || bus.gnt_cnt[N*CNT_W-1:CNT_W] !== '0) begin
        errors++; $display("FAIL cnt_sat cyc=%0d got=%h exp_cnt0=%0d others=0", c, bus.gnt_cnt, e);
      end
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) bus.weight = (N*WW)'($urandom);
      if ($urandom_range(0, 2) == 0) bus.req = N'($urandom);
      tick();
      checks++; if (bus.gnt !== exp_gnt()) begin errors++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", c, bus.gnt, exp_gnt()); end
      checks++; if (bus.gnt_vld !== m_busy) begin errors++; $display("FAIL rand_vld cyc=%0d got=%b exp=%b", c, bus.gnt_vld, m_busy); end
      checks++; if (int'(bus.gnt_id) != m_holder) begin errors++; $display("FAIL rand_id cyc=%0d got=%0d exp=%0d", c, bus.gnt_id, m_holder); end
      checks++; if ($countones(bus.gnt) > 1) begin errors++; $display("FAIL rand_onehot cyc=%0d got=%b exp=at most one bit", c, bus.gnt); end
`ifdef WRR_HOLD_GNT_CNT_EN
      for (int i = 0; i < N; i++) begin
        checks++;
        if (int'(bus.gnt_cnt[i*CNT_W +: CNT_W]) != m_cnt[i]) begin
          errors++; $display("FAIL rand_cnt cyc=%0d req=%0d got=%0d exp=%0d", c, i, bus.gnt_cnt[i*CNT_W +: CNT_W], m_cnt[i]);
        end
      end
`endif
    end
  endtask

  initial begin
    bus.req    = '0;
    bus.weight = '0;
    model_reset();
    test_reset();
    test_equal_weights();
    test_weighted();
    test_single_pulse();
    test_drop_handoff();
    test_async_reset();
`ifdef WRR_HOLD_GNT_CNT_EN
    test_cnt_saturate();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
